// File: rtl/bus_pkg.sv
// Shared definitions for the two-requester bus arbiter: FSM encoding and abort data.
package bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } bus_state_e;

   localparam logic [7:0] BUS_ABORT_DATA = 8'hFF;

endpackage

// File: rtl/bus_arb_timer.sv
// BUSY-phase watchdog for bus_arbiter; only instantiated when BUS_ARB_TIMEOUT_EN is defined.
module bus_arb_timer #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic busy,
   input  logic s_ready,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count_q, count_d;

   // Expires during the TIMEOUT_CYCLES-th consecutive BUSY cycle without s_ready.
   assign expired = busy && !s_ready && (count_q == CNT_LAST);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (busy && !s_ready) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Two-requester round-robin bus arbiter with a single shared slave port.
// Optional BUSY watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | sample requests, latch winner's address/data/direction
// BUSY  | slave strobe asserted, waiting for s_ready
// DONE  | one-cycle wait-low pulse to the granted requester
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic              m0_read,
   input  logic              m0_write,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_wait,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic              m1_read,
   input  logic              m1_write,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_wait,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   output logic              s_read,
   output logic              s_write,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic              s_ready,
   output logic              grant,
   output logic              timeout_flag
);

   bus_state_e        st_q, st_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              grant_q, grant_d;
   logic              last_q, last_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic [1:0]        wait_q, wait_d;
   logic              tflag_q, tflag_d;
   logic [1:0]        req;
   logic              win;
   logic              timeout_hit;

`ifdef BUS_ARB_TIMEOUT_EN
   bus_arb_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  ((st_q == ST_IDLE) && (st_d == ST_BUSY)),
      .busy   (st_q == ST_BUSY),
      .s_ready(s_ready),
      .expired(timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   assign req = {m1_read | m1_write, m0_read | m0_write};
   // On a tie the requester not granted last wins; otherwise the sole requester.
   assign win = (req == 2'b11) ? ~last_q : req[1];

   always_comb begin
      st_d     = st_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      grant_d  = grant_q;
      last_d   = last_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      wait_d   = 2'b11;
      tflag_d  = tflag_q;
      case (st_q)
         ST_IDLE: begin
            if (req != 2'b00) begin
               addr_d  = win ? m1_addr  : m0_addr;
               wdata_d = win ? m1_wdata : m0_wdata;
               rd_d    = win ? m1_read  : m0_read;
               wr_d    = win ? (m1_write & ~m1_read) : (m0_write & ~m0_read);
               grant_d = win;
               last_d  = win;
               st_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (s_ready || timeout_hit) begin
               if (rd_q) begin
                  if (grant_q) rdata1_d = s_ready ? s_rdata : DATA_W'(BUS_ABORT_DATA);
                  else         rdata0_d = s_ready ? s_rdata : DATA_W'(BUS_ABORT_DATA);
               end
               wait_d[grant_q] = 1'b0;
               rd_d            = 1'b0;
               wr_d            = 1'b0;
               if (!s_ready) tflag_d = 1'b1;
               st_d            = ST_DONE;
            end
         end
         ST_DONE: st_d = ST_IDLE;
         default: st_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q     <= ST_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         grant_q  <= 1'b0;
         last_q   <= 1'b1;
         rdata0_q <= '0;
         rdata1_q <= '0;
         wait_q   <= 2'b11;
         tflag_q  <= 1'b0;
      end else begin
         st_q     <= st_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         wait_q   <= wait_d;
         tflag_q  <= tflag_d;
      end
   end

   assign s_addr       = addr_q;
   assign s_wdata      = wdata_q;
   assign s_read       = rd_q;
   assign s_write      = wr_q;
   assign grant        = grant_q;
   assign m0_rdata     = rdata0_q;
   assign m1_rdata     = rdata1_q;
   assign m0_wait      = wait_q[0];
   assign m1_wait      = wait_q[1];
   assign timeout_flag = tflag_q;

endmodule
